// File: rtl/bcd_counter_0to99_disp.sv
// -----------------------------------------------------------------------------
// bcd_counter_0to99_disp
//
// Two-digit BCD event counter (00..99, up or down, wrapping). It steps once per
// rising edge of clk_1Hz, which is sampled as data in the clk_50MHz domain. The
// count is shown on a two-digit, time-multiplexed seven-segment display.
//
// Ports
//   clk_50MHz       in   1  single clock, rising edge
//   reset_button_n  in   1  synchronous active-low reset
//   clk_1Hz         in   1  step source (registered, same clock domain)
//   up_down         in   1  1 = count up, 0 = count down (sampled on step)
//   pause           in   1  1 = discard steps detected in this cycle
//   bcd_tens        out  4  tens digit 0..9
//   bcd_ones        out  4  ones digit 0..9
//   tick            out  1  one-cycle pulse per applied step
//   wrap            out  1  one-cycle pulse on 99->00 (up) or 00->99 (down)
//   seg             out  7  segments {g,f,e,d,c,b,a}
//   dp              out  1  decimal point, held inactive
//   digit_en        out  2  bit0 = ones digit, bit1 = tens digit
// -----------------------------------------------------------------------------
module bcd_counter_0to99_disp #(
    parameter int unsigned REFRESH_DIV    = 25000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1,
    parameter bit          BLANK_LEADING  = 1'b0
) (
    input  logic       clk_50MHz,
    input  logic       reset_button_n,
    input  logic       clk_1Hz,
    input  logic       up_down,
    input  logic       pause,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       tick,
    output logic       wrap,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] digit_en
);

    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned SEG_W     = 7;
    localparam int unsigned EN_W      = 2;
    localparam int unsigned REFRESH_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_DIV - 1);

    // XOR masks: applying the mask to an active-high value yields the pin level;
    // the mask itself is the "everything off" level.
    localparam logic [SEG_W-1:0] SEG_OFF = {SEG_W{SEG_ACTIVE_LOW}};
    localparam logic [EN_W-1:0]  DIG_OFF = {EN_W{DIG_ACTIVE_LOW}};
    localparam logic             DP_OFF  = SEG_ACTIVE_LOW;

    localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(9);

    // Active-high seven-segment pattern for one BCD digit; illegal codes blank.
    function automatic logic [SEG_W-1:0] seg_decode(input logic [DIGIT_W-1:0] digit);
        logic [SEG_W-1:0] pattern;
        case (digit)
            4'd0:    pattern = 7'h3F;
            4'd1:    pattern = 7'h06;
            4'd2:    pattern = 7'h5B;
            4'd3:    pattern = 7'h4F;
            4'd4:    pattern = 7'h66;
            4'd5:    pattern = 7'h6D;
            4'd6:    pattern = 7'h7D;
            4'd7:    pattern = 7'h07;
            4'd8:    pattern = 7'h7F;
            4'd9:    pattern = 7'h6F;
            default: pattern = 7'h00;
        endcase
        return pattern;
    endfunction

    // ------------------------------------------------------------------------
    // Step detection
    // ------------------------------------------------------------------------
    logic prev_1Hz;
    logic step_detect;
    logic step;

    assign step_detect = clk_1Hz & ~prev_1Hz;
    assign step        = step_detect & ~pause;

    // ------------------------------------------------------------------------
    // Next count. Illegal digits are forced to 0 by any applied step and never
    // generate a carry or borrow into the other digit.
    // ------------------------------------------------------------------------
    logic [DIGIT_W-1:0] tens_next;
    logic [DIGIT_W-1:0] ones_next;
    logic               wrap_next;

    always_comb begin
        tens_next = (bcd_tens > DIGIT_MAX) ? '0 : bcd_tens;
        ones_next = '0;
        wrap_next = 1'b0;

        if (up_down) begin
            if (bcd_ones < DIGIT_MAX) begin
                ones_next = bcd_ones + DIGIT_W'(1);
            end else if (bcd_ones == DIGIT_MAX) begin
                ones_next = '0;
                if (bcd_tens == DIGIT_MAX) begin
                    tens_next = '0;
                    wrap_next = 1'b1;
                end else if (bcd_tens < DIGIT_MAX) begin
                    tens_next = bcd_tens + DIGIT_W'(1);
                end
            end
        end else begin
            if (bcd_ones > DIGIT_MAX) begin
                ones_next = '0;
            end else if (bcd_ones == '0) begin
                ones_next = DIGIT_MAX;
                if (bcd_tens == '0) begin
                    tens_next = DIGIT_MAX;
                    wrap_next = 1'b1;
                end else if (bcd_tens <= DIGIT_MAX) begin
                    tens_next = bcd_tens - DIGIT_W'(1);
                end
            end else begin
                ones_next = bcd_ones - DIGIT_W'(1);
            end
        end
    end

    // Counter state, step pulses and edge-detect history.
    always_ff @(posedge clk_50MHz) begin
        if (!reset_button_n) begin
            // prev_1Hz = 1 so a high clk_1Hz at release is not seen as an edge
            prev_1Hz <= 1'b1;
            bcd_tens <= '0;
            bcd_ones <= '0;
            tick     <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            prev_1Hz <= clk_1Hz;
            tick     <= step;
            wrap     <= step & wrap_next;
            if (step) begin
                bcd_tens <= tens_next;
                bcd_ones <= ones_next;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Display multiplexer
    // ------------------------------------------------------------------------
    logic [REFRESH_W-1:0] refresh_cnt;
    logic                 sel;
    logic [DIGIT_W-1:0]   shown_digit;
    logic                 blank;
    logic [SEG_W-1:0]     seg_raw;
    logic [EN_W-1:0]      digit_raw;

    always_comb begin
        shown_digit = sel ? bcd_tens : bcd_ones;
        blank       = BLANK_LEADING && sel && (bcd_tens == '0);
        seg_raw     = blank ? '0 : seg_decode(shown_digit);
        digit_raw   = sel ? 2'b10 : 2'b01;
    end

    // Refresh timer and slot select.
    always_ff @(posedge clk_50MHz) begin
        if (!reset_button_n) begin
            refresh_cnt <= '0;
            sel         <= 1'b0;
        end else if (refresh_cnt == REFRESH_LAST) begin
            refresh_cnt <= '0;
            sel         <= ~sel;
        end else begin
            refresh_cnt <= refresh_cnt + REFRESH_W'(1);
        end
    end

    // Segment and digit drivers share one register stage so they switch together.
    always_ff @(posedge clk_50MHz) begin
        if (!reset_button_n) begin
            seg      <= SEG_OFF;
            dp       <= DP_OFF;
            digit_en <= DIG_OFF;
        end else begin
            seg      <= seg_raw ^ SEG_OFF;
            dp       <= DP_OFF;
            digit_en <= digit_raw ^ DIG_OFF;
        end
    end

endmodule

// File: tb/tb_bcd_counter_0to99_disp.sv
// -----------------------------------------------------------------------------
// tb_bcd_counter_0to99_disp
//
// Self-checking bench. dut0 uses REFRESH_DIV=4 without leading blanking, dut1
// is identical but blanks a leading zero. A scoreboard queue holds the
// expected count for each applied step; a negedge monitor pops it in the cycle
// the step must appear and checks both DUTs every cycle.
// -----------------------------------------------------------------------------
module tb_bcd_counter_0to99_disp;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_1hz;
    logic       up_down;
    logic       pause;

    logic [3:0] tens0, ones0, tens1, ones1;
    logic       tick0, wrap0, tick1, wrap1;
    logic [6:0] seg0, seg1;
    logic       dp0, dp1;
    logic [1:0] en0, en1;

    bcd_counter_0to99_disp #(
        .REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)
    ) dut0 (
        .clk_50MHz(clk), .reset_button_n(rst_n), .clk_1Hz(clk_1hz), .up_down(up_down),
        .pause(pause), .bcd_tens(tens0), .bcd_ones(ones0), .tick(tick0), .wrap(wrap0),
        .seg(seg0), .dp(dp0), .digit_en(en0)
    );

    bcd_counter_0to99_disp #(
        .REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)
    ) dut1 (
        .clk_50MHz(clk), .reset_button_n(rst_n), .clk_1Hz(clk_1hz), .up_down(up_down),
        .pause(pause), .bcd_tens(tens1), .bcd_ones(ones1), .tick(tick1), .wrap(wrap1),
        .seg(seg1), .dp(dp1), .digit_en(en1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tens;
        int ones;
        bit wrap;
        int due;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   model_val = 0;
    int   shown_val = 0;
    int   tick_cnt = 0;
    int   wrap_cnt = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    exp_t mon_e;
    bit   m_tick;
    bit   m_wrap;

    // Clock edges since reset release (1 after the first released edge).
    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    // Expected active-low segment pins for a digit.
    function automatic logic [6:0] exp_seg(input int digit, input bit blank);
        logic [6:0] hi;
        case (digit)
            0: hi = 7'h3F;  1: hi = 7'h06;  2: hi = 7'h5B;  3: hi = 7'h4F;
            4: hi = 7'h66;  5: hi = 7'h6D;  6: hi = 7'h7D;  7: hi = 7'h07;
            8: hi = 7'h7F;  9: hi = 7'h6F;
            default: hi = 7'h00;
        endcase
        if (blank) hi = 7'h00;
        return ~hi;
    endfunction

    // Scoreboard monitor: a step is due exactly one cycle after it is driven.
    always @(negedge clk) begin
        if (mon_en) begin
            if (tick0 === 1'b1) tick_cnt++;
            if (wrap0 === 1'b1) wrap_cnt++;
            m_tick = 1'b0;
            m_wrap = 1'b0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e     = sb.pop_front();
                m_tick    = 1'b1;
                m_wrap    = mon_e.wrap;
                shown_val = mon_e.tens * 10 + mon_e.ones;
            end
            checks++;
            if ({tick0, wrap0, tens0, ones0} !== {m_tick, m_wrap, 4'(shown_val / 10), 4'(shown_val % 10)}) begin
                errors++;
                $display("FAIL dut0_count @cyc %0d: got tick=%0b wrap=%0b count=%0d%0d, want tick=%0b wrap=%0b count=%02d",
                         cyc, tick0, wrap0, tens0, ones0, m_tick, m_wrap, shown_val);
            end
            checks++;
            if ({tick1, wrap1, tens1, ones1} !== {m_tick, m_wrap, 4'(shown_val / 10), 4'(shown_val % 10)}) begin
                errors++;
                $display("FAIL dut1_count @cyc %0d: got tick=%0b wrap=%0b count=%0d%0d, want tick=%0b wrap=%0b count=%02d",
                         cyc, tick1, wrap1, tens1, ones1, m_tick, m_wrap, shown_val);
            end
        end
    end

    // One clk_1Hz rising edge (two clocks: low then high); pushes the expected result.
    task automatic step_edge(input bit up, input bit hold);
        exp_t e;
        int   old;
        @(negedge clk);
        clk_1hz = 1'b0;
        @(negedge clk);
        clk_1hz = 1'b1;
        up_down = up;
        pause   = hold;
        if (!hold) begin
            old       = model_val;
            model_val = up ? (old + 1) % 100 : (old + 99) % 100;
            e.wrap    = up ? (old == 99) : (old == 0);
            e.tens    = model_val / 10;
            e.ones    = model_val % 10;
            e.due     = cyc + 1;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 8) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: %0d expected steps never appeared", tag, sb.size());
        end
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        mon_en  = 1'b0;
        rst_n   = 1'b0;
        clk_1hz = 1'b0;
        pause   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        sb.delete();
        model_val = 0;
        shown_val = 0;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        bit         s;
        logic [1:0] want_en;
        @(negedge clk);
        mon_en  = 1'b0;
        rst_n   = 1'b0;
        clk_1hz = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({tens0, ones0, tick0, wrap0} !== 10'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d%0d tick=%0b wrap=%0b, want 00 tick=0 wrap=0", tens0, ones0, tick0, wrap0);
        end
        checks++;
        if ({seg0, dp0, en0} !== {7'h7F, 1'b1, 2'b11}) begin
            errors++;
            $display("FAIL reset_disp0: got seg=%h dp=%b en=%b, want seg=7f dp=1 en=11", seg0, dp0, en0);
        end
        checks++;
        if ({seg1, dp1, en1} !== {7'h7F, 1'b1, 2'b11}) begin
            errors++;
            $display("FAIL reset_disp1: got seg=%h dp=%b en=%b, want seg=7f dp=1 en=11", seg1, dp1, en1);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            checks++;
            if ({tens0, ones0, tick0, tens1, ones1, tick1} !== 18'd0) begin
                errors++;
                $display("FAIL release_hold cycle %0d: got %0d%0d tick=%0b / %0d%0d tick=%0b, want 00 tick=0",
                         i, tens0, ones0, tick0, tens1, ones1, tick1);
            end
            if (i == 1) begin
                checks++;
                if (en0 !== 2'b10 || seg0 !== 7'h40) begin
                    errors++;
                    $display("FAIL first_cycle: got en=%b seg=%h, want en=10 seg=40", en0, seg0);
                end
            end
            s       = (((cyc - 1) / DIV) % 2) == 1;
            want_en = s ? 2'b01 : 2'b10;
            checks++;
            if (en0 !== want_en || seg0 !== exp_seg(0, 1'b0) || en1 !== want_en || seg1 !== exp_seg(0, s)) begin
                errors++;
                $display("FAIL release_mux cycle %0d: got en0=%b seg0=%h en1=%b seg1=%h, want en=%b seg0=%h seg1=%h",
                         i, en0, seg0, en1, seg1, want_en, exp_seg(0, 1'b0), exp_seg(0, s));
            end
        end
        sb.delete();
        model_val = 0;
        shown_val = 0;
        mon_en    = 1'b1;
    endtask

    task automatic test_up_wrap();
        int t0 = tick_cnt;
        int w0 = wrap_cnt;
        for (int i = 0; i < 100; i++) step_edge(1'b1, 1'b0);
        wait_drain("up");
        checks++;
        if (tick_cnt - t0 != 100 || wrap_cnt - w0 != 1) begin
            errors++;
            $display("FAIL up_pulses: got ticks=%0d wraps=%0d, want ticks=100 wraps=1", tick_cnt - t0, wrap_cnt - w0);
        end
        checks++;
        if ({tens0, ones0} !== 8'h00) begin
            errors++;
            $display("FAIL up_end: got %0d%0d, want 00", tens0, ones0);
        end
    endtask

    task automatic test_down_wrap();
        int t0 = tick_cnt;
        int w0 = wrap_cnt;
        for (int i = 0; i < 11; i++) step_edge(1'b0, 1'b0);
        wait_drain("down");
        checks++;
        if (tick_cnt - t0 != 11 || wrap_cnt - w0 != 1) begin
            errors++;
            $display("FAIL down_pulses: got ticks=%0d wraps=%0d, want ticks=11 wraps=1", tick_cnt - t0, wrap_cnt - w0);
        end
        checks++;
        if ({tens0, ones0} !== 8'h89) begin
            errors++;
            $display("FAIL down_end: got %0d%0d, want 89", tens0, ones0);
        end
    endtask

    task automatic test_pause();
        int t0    = tick_cnt;
        int start = model_val;
        for (int i = 0; i < 3; i++) step_edge(1'b1, 1'b1);
        @(negedge clk);
        pause = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (tick_cnt != t0 || tens0 !== 4'(start / 10) || ones0 !== 4'(start % 10)) begin
            errors++;
            $display("FAIL pause_hold: got ticks=%0d count=%0d%0d, want ticks=0 count=%02d", tick_cnt - t0, tens0, ones0, start);
        end
        step_edge(1'b1, 1'b0);
        wait_drain("pause");
        checks++;
        if (tick_cnt - t0 != 1 || tens0 !== 4'(((start + 1) % 100) / 10) || ones0 !== 4'((start + 1) % 10)) begin
            errors++;
            $display("FAIL pause_resume: got ticks=%0d count=%0d%0d, want ticks=1 count=%02d",
                     tick_cnt - t0, tens0, ones0, (start + 1) % 100);
        end
    endtask

    task automatic test_back_to_back();
        int t0      = tick_cnt;
        int applied = 0;
        bit up;
        bit hold;
        for (int i = 0; i < 40; i++) begin
            up   = 1'($urandom_range(0, 1));
            hold = ($urandom_range(0, 3) == 0);
            if (!hold) applied++;
            step_edge(up, hold);
        end
        wait_drain("b2b");
        checks++;
        if (tick_cnt - t0 != applied) begin
            errors++;
            $display("FAIL b2b_ticks: got %0d, want %0d", tick_cnt - t0, applied);
        end
    endtask

    task automatic test_display();
        int         val;
        int         tn;
        int         on;
        bit         s;
        logic [1:0] want_en;
        logic [6:0] want0;
        logic [6:0] want1;
        for (int k = 0; k < 2; k++) begin
            val = (k == 0) ? 57 : 7;
            do_reset();
            for (int i = 0; i < val; i++) step_edge(1'b1, 1'b0);
            wait_drain("disp");
            @(negedge clk);
            clk_1hz = 1'b0;
            repeat (2) @(negedge clk);
            tn = val / 10;
            on = val % 10;
            for (int c = 0; c < 4 * int'(DIV); c++) begin
                @(negedge clk);
                s       = (((cyc - 1) / DIV) % 2) == 1;
                want_en = s ? 2'b01 : 2'b10;
                want0   = exp_seg(s ? tn : on, 1'b0);
                want1   = exp_seg(s ? tn : on, s && (tn == 0));
                checks++;
                if (en0 !== want_en || seg0 !== want0 || dp0 !== 1'b1) begin
                    errors++;
                    $display("FAIL mux0 count %02d cyc %0d: got en=%b seg=%h dp=%b, want en=%b seg=%h dp=1",
                             val, cyc, en0, seg0, dp0, want_en, want0);
                end
                checks++;
                if (en1 !== want_en || seg1 !== want1 || dp1 !== 1'b1) begin
                    errors++;
                    $display("FAIL mux1 count %02d cyc %0d: got en=%b seg=%h dp=%b, want en=%b seg=%h dp=1",
                             val, cyc, en1, seg1, dp1, want_en, want1);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int t0;
        do_reset();
        for (int i = 0; i < 42; i++) step_edge(1'b1, 1'b0);
        wait_drain("to42");
        @(negedge clk);
        clk_1hz = 1'b0;
        @(negedge clk);
        mon_en  = 1'b0;
        clk_1hz = 1'b1;
        up_down = 1'b1;
        pause   = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        checks++;
        if ({tens0, ones0, tick0, tens1, ones1, tick1} !== 18'd0) begin
            errors++;
            $display("FAIL mid_reset: got %0d%0d tick=%0b / %0d%0d tick=%0b, want 00 tick=0",
                     tens0, ones0, tick0, tens1, ones1, tick1);
        end
        rst_n     = 1'b1;
        sb.delete();
        model_val = 0;
        shown_val = 0;
        t0        = tick_cnt;
        @(negedge clk);
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        step_edge(1'b1, 1'b0);
        wait_drain("mid");
        checks++;
        if (tick_cnt - t0 != 1 || {tens0, ones0} !== 8'h01) begin
            errors++;
            $display("FAIL mid_resume: got ticks=%0d count=%0d%0d, want ticks=1 count=01", tick_cnt - t0, tens0, ones0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        clk_1hz = 1'b1;
        up_down = 1'b1;
        pause   = 1'b0;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_pause();
        test_back_to_back();
        test_display();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
